// File: rtl/mem_pipe_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_pipe_stage
// Brief    : Elastic datapath stage register, valid/ready, optional 2-entry skid
// Revision : 1.0 - initial release
// ============================================================================
module mem_pipe_stage #(
  parameter int CTRL_W = 16,
  parameter int DATA_W = 96,
  parameter int SKID   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  logic              w_in_fire;
  logic              w_out_fire;
  logic [CTRL_W-1:0] r_main_ctrl;
  logic [DATA_W-1:0] r_main_data;

  assign w_in_fire  = in_valid & in_ready;
  assign w_out_fire = out_valid & out_ready;
  // Invalid stages must never present live enables downstream.
  assign out_ctrl   = out_valid ? r_main_ctrl : '0;
  assign out_data   = r_main_data;

  generate
    if (SKID != 0) begin : g_skid
      state_t            r_state;
      state_t            w_state_nxt;
      logic              r_in_ready;
      logic [CTRL_W-1:0] r_skid_ctrl;
      logic [DATA_W-1:0] r_skid_data;

      assign in_ready  = r_in_ready;
      assign out_valid = (r_state != S_EMPTY);
      assign occupancy = r_state;

      always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
          w_state_nxt = S_EMPTY;
        end else begin
          case (r_state)
            S_EMPTY: if (w_in_fire) w_state_nxt = S_ONE;
            S_ONE: begin
              if (w_in_fire && !w_out_fire)      w_state_nxt = S_FULL;
              else if (!w_in_fire && w_out_fire) w_state_nxt = S_EMPTY;
            end
            S_FULL:  if (w_out_fire) w_state_nxt = S_ONE;
            default: w_state_nxt = S_EMPTY;
          endcase
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_state     <= S_EMPTY;
          r_in_ready  <= 1'b0;
          r_main_ctrl <= '0;
          r_main_data <= '0;
          r_skid_ctrl <= '0;
          r_skid_data <= '0;
        end else begin
          r_state <= w_state_nxt;
          // Ready is a pure function of the next state, so no out_ready path.
          r_in_ready <= (w_state_nxt != S_FULL);
          if (flush) begin
            r_main_ctrl <= '0;
            r_skid_ctrl <= '0;
          end else begin
            case (r_state)
              S_EMPTY: begin
                if (w_in_fire) begin
                  r_main_ctrl <= in_ctrl;
                  r_main_data <= in_data;
                end
              end
              S_ONE: begin
                if (w_in_fire && w_out_fire) begin
                  r_main_ctrl <= in_ctrl;
                  r_main_data <= in_data;
                end else if (w_in_fire) begin
                  r_skid_ctrl <= in_ctrl;
                  r_skid_data <= in_data;
                end
              end
              S_FULL: begin
                if (w_out_fire) begin
                  r_main_ctrl <= r_skid_ctrl;
                  r_main_data <= r_skid_data;
                end
              end
              default: ;
            endcase
          end
        end
      end
    end else begin : g_noskid
      logic r_valid;

      assign in_ready  = ~r_valid | out_ready;
      assign out_valid = r_valid;
      assign occupancy = {1'b0, r_valid};

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_valid     <= 1'b0;
          r_main_ctrl <= '0;
          r_main_data <= '0;
        end else if (flush) begin
          r_valid     <= 1'b0;
          r_main_ctrl <= '0;
        end else if (w_in_fire) begin
          r_valid     <= 1'b1;
          r_main_ctrl <= in_ctrl;
          r_main_data <= in_data;
        end else if (w_out_fire) begin
          r_valid <= 1'b0;
        end
      end
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_mem_pipe_stage.sv
`default_nettype none
// Directed bench for mem_pipe_stage: one SKID=1 instance (a_*) and one SKID=0 instance (b_*).
module tb_mem_pipe_stage;

  localparam int CTRL_W = 16;
  localparam int DATA_W = 96;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic              a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [CTRL_W-1:0] a_in_ctrl, a_out_ctrl;
  logic [DATA_W-1:0] a_in_data, a_out_data;
  logic [1:0]        a_occ;

  logic              b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [CTRL_W-1:0] b_in_ctrl, b_out_ctrl;
  logic [DATA_W-1:0] b_in_data, b_out_data;
  logic [1:0]        b_occ;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mem_pipe_stage #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .SKID(1)) u_dut_skid (
    .clk(clk), .rst(rst), .flush(a_flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_ctrl(a_in_ctrl), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_ctrl(a_out_ctrl), .out_data(a_out_data),
    .occupancy(a_occ)
  );

  mem_pipe_stage #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .SKID(0)) u_dut_noskid (
    .clk(clk), .rst(rst), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_ctrl(b_in_ctrl), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_ctrl(b_out_ctrl), .out_data(b_out_data),
    .occupancy(b_occ)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_drive(input logic v, input logic [15:0] c, input logic [95:0] d);
    a_in_valid = v;
    a_in_ctrl  = c;
    a_in_data  = d;
  endtask

  task automatic a_out(input string tag, input logic v, input logic [15:0] c,
                       input logic [95:0] d, input logic [1:0] occ);
    check({tag, ".valid"}, a_out_valid, v);
    check({tag, ".ctrl"},  a_out_ctrl,  c);
    check({tag, ".data"},  a_out_data,  d);
    check({tag, ".occ"},   a_occ,       occ);
  endtask

  initial begin
    a_flush = 0; a_out_ready = 0; a_drive(0, '0, '0);
    b_flush = 0; b_out_ready = 0; b_in_valid = 0; b_in_ctrl = '0; b_in_data = '0;

    // Reset values
    tick(); tick();
    a_out("rst_a", 1'b0, 16'h0, 96'h0, 2'd0);
    check("rst_a.in_ready", a_in_ready, 1'b0);
    check("rst_b.in_ready", b_in_ready, 1'b1);
    check("rst_b.valid", b_out_valid, 1'b0);
    check("rst_b.occ", b_occ, 2'd0);
    #2 rst = 1'b0;
    tick();
    check("post_rst_a.in_ready", a_in_ready, 1'b1);

    // SKID=0: stall holds main, ready drops; raising out_ready reopens it combinationally
    b_in_valid = 1; b_in_ctrl = 16'h0011; b_in_data = 96'h111;
    tick();
    check("b_load.valid", b_out_valid, 1'b1);
    check("b_load.ctrl", b_out_ctrl, 16'h0011);
    b_in_ctrl = 16'h0022; b_in_data = 96'h222;
    #1 check("b_stall.in_ready", b_in_ready, 1'b0);
    tick();
    check("b_stall.ctrl", b_out_ctrl, 16'h0011);
    check("b_stall.data", b_out_data, 96'h111);
    b_out_ready = 1;
    #1 check("b_release.in_ready", b_in_ready, 1'b1);
    tick();
    check("b_replace.ctrl", b_out_ctrl, 16'h0022);
    check("b_replace.data", b_out_data, 96'h222);
    check("b_replace.occ", b_occ, 2'd1);
    b_in_valid = 0;
    tick();
    check("b_drain.valid", b_out_valid, 1'b0);
    check("b_drain.ctrl", b_out_ctrl, 16'h0);
    check("b_drain.data", b_out_data, 96'h222);
    b_out_ready = 0;

    // Streaming with out_ready high: one-cycle latency, no bubbles
    a_out_ready = 1;
    for (int i = 1; i <= 8; i++) begin
      a_drive(1, 16'(i), 96'(i));
      tick();
      a_out($sformatf("stream%0d", i), 1'b1, 16'(i), 96'(i), 2'd1);
      check($sformatf("stream%0d.in_ready", i), a_in_ready, 1'b1);
    end

    // Control gating on drain
    a_drive(1, 16'hFFFF, 96'hABC);
    tick();
    a_out("gate_load", 1'b1, 16'hFFFF, 96'hABC, 2'd1);
    a_drive(0, 16'h0, 96'h0);
    tick();
    a_out("gate_drain", 1'b0, 16'h0, 96'hABC, 2'd0);

    // Back-pressure: A held, B in skid, C held upstream
    a_out_ready = 0;
    a_drive(1, 16'h000A, 96'hA0);
    tick();
    a_out("bp_A", 1'b1, 16'h000A, 96'hA0, 2'd1);
    check("bp_A.in_ready", a_in_ready, 1'b1);
    a_drive(1, 16'h000B, 96'hB0);
    tick();
    a_out("bp_full", 1'b1, 16'h000A, 96'hA0, 2'd2);
    check("bp_full.in_ready", a_in_ready, 1'b0);
    a_drive(1, 16'h000C, 96'hC0);
    tick();
    a_out("bp_hold", 1'b1, 16'h000A, 96'hA0, 2'd2);
    check("bp_hold.in_ready", a_in_ready, 1'b0);
    a_out_ready = 1;
    tick();
    a_out("bp_B", 1'b1, 16'h000B, 96'hB0, 2'd1);
    check("bp_B.in_ready", a_in_ready, 1'b1);
    tick();
    a_out("bp_C", 1'b1, 16'h000C, 96'hC0, 2'd1);
    a_drive(0, 16'h0, 96'h0);
    tick();
    a_out("bp_empty", 1'b0, 16'h0, 96'hC0, 2'd0);

    // Flush while FULL with C offered, then flush with an accepted D while ONE
    a_out_ready = 0;
    a_drive(1, 16'h000A, 96'hA1); tick();
    a_drive(1, 16'h000B, 96'hB1); tick();
    check("fl_full.occ", a_occ, 2'd2);
    a_drive(1, 16'h000C, 96'hC1);
    a_flush = 1;
    tick();
    a_flush = 0;
    a_drive(0, 16'h0, 96'h0);
    check("fl1.valid", a_out_valid, 1'b0);
    check("fl1.ctrl", a_out_ctrl, 16'h0);
    check("fl1.occ", a_occ, 2'd0);
    check("fl1.in_ready", a_in_ready, 1'b1);
    a_drive(1, 16'h00E0, 96'hE0); tick();
    a_drive(1, 16'h00D0, 96'hD0);
    a_flush = 1;
    tick();
    a_flush = 0;
    a_drive(0, 16'h0, 96'h0);
    a_out_ready = 1;
    check("fl2.valid", a_out_valid, 1'b0);
    check("fl2.occ", a_occ, 2'd0);
    tick(); tick();
    check("fl_never.valid", a_out_valid, 1'b0);
    check("fl_never.ctrl", a_out_ctrl, 16'h0);

    // Asynchronous reset mid-cycle while FULL
    a_out_ready = 0;
    a_drive(1, 16'h0031, 96'h31); tick();
    a_drive(1, 16'h0032, 96'h32); tick();
    a_drive(0, 16'h0, 96'h0);
    check("ar_pre.occ", a_occ, 2'd2);
    #2 rst = 1'b1;
    #1;
    a_out("ar_now", 1'b0, 16'h0, 96'h0, 2'd0);
    check("ar_now.in_ready", a_in_ready, 1'b0);
    tick();
    #2 rst = 1'b0;
    tick();
    check("ar_post.in_ready", a_in_ready, 1'b1);
    check("ar_post.valid", a_out_valid, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
